// File: rtl/mem_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Groups the signals of the two-master memory bus arbiter:
//   Master 0 (CPU data port) and master 1 (UART loader) handshake:
//     mX_req, mX_addr, mX_wdata, mX_we     requester -> arbiter
//     mX_gnt, mX_ack, mX_err, mX_rdata     arbiter -> requester
//   Shared decoder-side bus:
//     bus_valid, bus_addr, bus_wdata, bus_we, bus_re   arbiter -> decoder
//     bus_rdata                                        decoder -> arbiter
// The slave modport is the arbiter's view. The master modport is the view of
// whatever sits around it: both requesters and the ROM/RAM/UART mux.
// ----------------------------------------------------------------------------
interface mem_bus_arbiter_if;

   logic        m0_req;
   logic        m1_req;
   logic [31:0] m0_addr;
   logic [31:0] m1_addr;
   logic [31:0] m0_wdata;
   logic [31:0] m1_wdata;
   logic        m0_we;
   logic        m1_we;

   logic        m0_gnt;
   logic        m1_gnt;
   logic        m0_ack;
   logic        m1_ack;
   logic        m0_err;
   logic        m1_err;
   logic [31:0] m0_rdata;
   logic [31:0] m1_rdata;

   logic        bus_valid;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_we;
   logic        bus_re;
   logic [31:0] bus_rdata;

   // Arbiter side: takes requests and decoder read data, drives everything else.
   modport slave (
      input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_we, m1_we,
      input  bus_rdata,
      output m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
      output bus_valid, bus_addr, bus_wdata, bus_we, bus_re
   );

   // Environment side: requesters and the decoder mux.
   modport master (
      output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_we, m1_we,
      output bus_rdata,
      input  m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
      input  bus_valid, bus_addr, bus_wdata, bus_we, bus_re
   );

endinterface

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
// Round-robin arbiter and access sequencer for the shared memory-mapped bus
// (ROM 0x000-0x3FF, RAM 0x400-0x4FF, UART data 0x500, UART status 0x504).
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bif    mem_bus_arbiter_if.slave: both master handshakes plus the
//          decoder-side bus (see the interface file for the signal list)
// Parameters:
//   WAIT_CYCLES  extra ACCESS cycles beyond the first (0-15)
//   PARK_ADDR    value on bus_addr whenever the bus is not in ACCESS
// Every output comes straight from a flop.
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] PARK_ADDR   = 32'h0
) (
   input logic              clk,
   input logic              reset,
   mem_bus_arbiter_if.slave bif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   state_t      state_q;
   logic        lastGrant_q;
   logic        owner_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  count_q;

   logic        m0Gnt_q;
   logic        m1Gnt_q;
   logic        m0Ack_q;
   logic        m1Ack_q;
   logic        m0Err_q;
   logic        m1Err_q;
   logic [31:0] m0Rdata_q;
   logic [31:0] m1Rdata_q;
   logic        busValid_q;
   logic [31:0] busAddr_q;
   logic [31:0] busWdata_q;
   logic        busWe_q;
   logic        busRe_q;

   logic        grantM1_d;
   logic [31:0] addr_d;
   logic [31:0] wdata_d;
   logic        we_d;
   logic        legal_d;

   // An access is legal when it hits one of the four mapped regions exactly.
   // The UART registers are single words, so only their base byte address
   // is accepted, and ROM is read-only.
   function automatic logic isLegal(input logic [31:0] a, input logic w);
      logic ok;
      ok = 1'b0;
      if (a <= 32'h0000_03FF) begin
         ok = !w;
      end else if (a <= 32'h0000_04FF) begin
         ok = 1'b1;
      end else if ((a == 32'h0000_0500) || (a == 32'h0000_0504)) begin
         ok = 1'b1;
      end
      return ok;
   endfunction

   // Arbitration choice for the IDLE cycle. lastGrant_q is 1 when master 1
   // had the bus last, so on a tie master 1 wins only if master 0 went last.
   // The winner's request fields are muxed here so they can be latched and
   // legality-checked in the same edge as the grant.
   always_comb begin
      grantM1_d = bif.m1_req && (!bif.m0_req || !lastGrant_q);
      addr_d    = grantM1_d ? bif.m1_addr  : bif.m0_addr;
      wdata_d   = grantM1_d ? bif.m1_wdata : bif.m0_wdata;
      we_d      = grantM1_d ? bif.m1_we    : bif.m0_we;
      legal_d   = isLegal(addr_d, we_d);
   end

   // Main sequencer. IDLE grants and either starts a bus access or, for an
   // illegal request, jumps straight to RESP with an error. ACCESS counts the
   // wait cycles down; the strobes are raised on the edge that enters the
   // last ACCESS cycle so they are high for exactly that cycle, and read data
   // is captured on the edge that leaves it. RESP pulses ack for one cycle
   // while the grant is still visible, then the bus returns to IDLE where a
   // still-held request is re-arbitrated.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         lastGrant_q <= 1'b1;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         count_q     <= 4'd0;
         m0Gnt_q     <= 1'b0;
         m1Gnt_q     <= 1'b0;
         m0Ack_q     <= 1'b0;
         m1Ack_q     <= 1'b0;
         m0Err_q     <= 1'b0;
         m1Err_q     <= 1'b0;
         m0Rdata_q   <= 32'h0;
         m1Rdata_q   <= 32'h0;
         busValid_q  <= 1'b0;
         busAddr_q   <= PARK_ADDR;
         busWdata_q  <= 32'h0;
         busWe_q     <= 1'b0;
         busRe_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bif.m0_req || bif.m1_req) begin
                  owner_q     <= grantM1_d;
                  lastGrant_q <= grantM1_d;
                  addr_q      <= addr_d;
                  wdata_q     <= wdata_d;
                  we_q        <= we_d;
                  m0Gnt_q     <= !grantM1_d;
                  m1Gnt_q     <= grantM1_d;
                  if (legal_d) begin
                     state_q    <= ACCESS;
                     count_q    <= WAIT_LOAD;
                     busValid_q <= 1'b1;
                     busAddr_q  <= addr_d;
                     busWdata_q <= wdata_d;
                     if (WAIT_LOAD == 4'd0) begin
                        busWe_q <= we_d;
                        busRe_q <= !we_d;
                     end
                  end else begin
                     state_q <= RESP;
                     if (grantM1_d) begin
                        m1Ack_q   <= 1'b1;
                        m1Err_q   <= 1'b1;
                        m1Rdata_q <= 32'h0;
                     end else begin
                        m0Ack_q   <= 1'b1;
                        m0Err_q   <= 1'b1;
                        m0Rdata_q <= 32'h0;
                     end
                  end
               end
            end

            ACCESS: begin
               if (count_q == 4'd0) begin
                  state_q    <= RESP;
                  busValid_q <= 1'b0;
                  busWe_q    <= 1'b0;
                  busRe_q    <= 1'b0;
                  busAddr_q  <= PARK_ADDR;
                  busWdata_q <= 32'h0;
                  if (owner_q) begin
                     m1Ack_q <= 1'b1;
                     m1Err_q <= 1'b0;
                     if (!we_q) begin
                        m1Rdata_q <= bif.bus_rdata;
                     end
                  end else begin
                     m0Ack_q <= 1'b1;
                     m0Err_q <= 1'b0;
                     if (!we_q) begin
                        m0Rdata_q <= bif.bus_rdata;
                     end
                  end
               end else begin
                  count_q <= count_q - 4'd1;
                  if (count_q == 4'd1) begin
                     busWe_q <= we_q;
                     busRe_q <= !we_q;
                  end
               end
            end

            RESP: begin
               state_q <= IDLE;
               m0Gnt_q <= 1'b0;
               m1Gnt_q <= 1'b0;
               m0Ack_q <= 1'b0;
               m1Ack_q <= 1'b0;
               m0Err_q <= 1'b0;
               m1Err_q <= 1'b0;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Registered state drives the interface directly.
   assign bif.m0_gnt    = m0Gnt_q;
   assign bif.m1_gnt    = m1Gnt_q;
   assign bif.m0_ack    = m0Ack_q;
   assign bif.m1_ack    = m1Ack_q;
   assign bif.m0_err    = m0Err_q;
   assign bif.m1_err    = m1Err_q;
   assign bif.m0_rdata  = m0Rdata_q;
   assign bif.m1_rdata  = m1Rdata_q;
   assign bif.bus_valid = busValid_q;
   assign bif.bus_addr  = busAddr_q;
   assign bif.bus_wdata = busWdata_q;
   assign bif.bus_we    = busWe_q;
   assign bif.bus_re    = busRe_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter. The main instance runs with one wait
// cycle and a non-zero park address; a second instance runs with zero wait
// cycles. Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   localparam logic [31:0] PARK = 32'h0000_0F00;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int total = 0;
   int bad   = 0;

   bit          sawValid;
   int          weCycles;
   int          reCycles;
   logic [31:0] weAddr;
   logic [31:0] weData;

   mem_bus_arbiter_if bif ();
   mem_bus_arbiter_if bif0 ();

   mem_bus_arbiter #(.WAIT_CYCLES(1), .PARK_ADDR(PARK)) dut (
      .clk   (clk),
      .reset (reset),
      .bif   (bif)
   );

   mem_bus_arbiter #(.WAIT_CYCLES(0), .PARK_ADDR(32'h0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bif   (bif0)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Safety net so a stuck bench still ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   // Drive every requester and decoder input of both instances to idle.
   task automatic clearInputs();
      bif.m0_req = 1'b0;  bif.m1_req = 1'b0;
      bif.m0_addr = '0;   bif.m1_addr = '0;
      bif.m0_wdata = '0;  bif.m1_wdata = '0;
      bif.m0_we = 1'b0;   bif.m1_we = 1'b0;
      bif.bus_rdata = '0;
      bif0.m0_req = 1'b0; bif0.m1_req = 1'b0;
      bif0.m0_addr = '0;  bif0.m1_addr = '0;
      bif0.m0_wdata = '0; bif0.m1_wdata = '0;
      bif0.m0_we = 1'b0;  bif0.m1_we = 1'b0;
      bif0.bus_rdata = '0;
   endtask

   // Pulse reset and leave the bench on a falling edge with the DUTs idle.
   task automatic doReset();
      reset = 1'b1;
      clearInputs();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Issue one request on the main instance from IDLE and wait for its ack,
   // recording bus activity on the way. Returns on the ack cycle's falling
   // edge with the request dropped; ackCyc is -1 if no ack came.
   task automatic runAccess(input bit m, input logic [31:0] a, input logic [31:0] wd,
                            input bit w, output int ackCyc);
      ackCyc = -1; sawValid = 1'b0; weCycles = 0; reCycles = 0; weAddr = '0; weData = '0;
      if (m) begin
         bif.m1_req = 1'b1; bif.m1_addr = a; bif.m1_wdata = wd; bif.m1_we = w;
      end else begin
         bif.m0_req = 1'b1; bif.m0_addr = a; bif.m0_wdata = wd; bif.m0_we = w;
      end
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bif.bus_valid) sawValid = 1'b1;
         if (bif.bus_we) begin
            weCycles++; weAddr = bif.bus_addr; weData = bif.bus_wdata;
         end
         if (bif.bus_re) reCycles++;
         if ((m && bif.m1_ack) || (!m && bif.m0_ack)) begin
            ackCyc = k;
            break;
         end
      end
      if (m) bif.m1_req = 1'b0; else bif.m0_req = 1'b0;
   endtask

   // Reset values of every output, then one quiet cycle after release.
   task automatic test_reset();
      clearInputs();
      reset = 1'b1;
      @(negedge clk);
      total++;
      if ({bif.m0_gnt, bif.m1_gnt, bif.m0_ack, bif.m1_ack, bif.m0_err, bif.m1_err,
           bif.bus_valid, bif.bus_we, bif.bus_re} !== 9'b0) begin
         bad++;
         $display("[TB] FAIL reset_flags got=%b exp=0", {bif.m0_gnt, bif.m1_gnt, bif.m0_ack,
                  bif.m1_ack, bif.m0_err, bif.m1_err, bif.bus_valid, bif.bus_we, bif.bus_re});
      end
      total++;
      if (bif.m0_rdata !== 32'h0 || bif.m1_rdata !== 32'h0) begin
         bad++;
         $display("[TB] FAIL reset_rdata got=%h/%h exp=0", bif.m0_rdata, bif.m1_rdata);
      end
      total++;
      if (bif.bus_addr !== PARK) begin
         bad++;
         $display("[TB] FAIL reset_bus_addr got=%h exp=%h", bif.bus_addr, PARK);
      end
      total++;
      if (bif.bus_wdata !== 32'h0) begin
         bad++;
         $display("[TB] FAIL reset_bus_wdata got=%h exp=0", bif.bus_wdata);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({bif.m0_gnt, bif.m1_gnt, bif.bus_valid} !== 3'b0 || bif.bus_addr !== PARK) begin
         bad++;
         $display("[TB] FAIL reset_idle got=%b addr=%h exp=000 addr=%h",
                  {bif.m0_gnt, bif.m1_gnt, bif.bus_valid}, bif.bus_addr, PARK);
      end
   endtask

   // m0 reads RAM 0x404: two ACCESS cycles, read strobe in the second only,
   // ack two cycles after the ACCESS starts, request changes after grant ignored.
   task automatic test_read();
      doReset();
      bif.m0_req = 1'b1; bif.m0_addr = 32'h404; bif.m0_we = 1'b0; bif.m0_wdata = 32'h55;
      bif.bus_rdata = 32'hDEAD_BEEF;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         total++;
         if (bif.bus_valid !== (k <= 2)) begin
            bad++;
            $display("[TB] FAIL read_valid k=%0d got=%b exp=%b", k, bif.bus_valid, (k <= 2));
         end
         total++;
         if (bif.bus_re !== (k == 2) || bif.bus_we !== 1'b0) begin
            bad++;
            $display("[TB] FAIL read_strobe k=%0d got re=%b we=%b exp re=%b we=0",
                     k, bif.bus_re, bif.bus_we, (k == 2));
         end
         total++;
         if (bif.m0_ack !== (k == 3) || bif.m0_gnt !== (k <= 3)) begin
            bad++;
            $display("[TB] FAIL read_ack_gnt k=%0d got ack=%b gnt=%b exp ack=%b gnt=%b",
                     k, bif.m0_ack, bif.m0_gnt, (k == 3), (k <= 3));
         end
         if (k == 1) begin
            bif.m0_addr = 32'h123; bif.m0_we = 1'b1;
         end
         if (k == 2) begin
            total++;
            if (bif.bus_addr !== 32'h404) begin
               bad++;
               $display("[TB] FAIL read_latched_addr got=%h exp=00000404", bif.bus_addr);
            end
         end
         if (k == 3) begin
            total++;
            if (bif.m0_rdata !== 32'hDEAD_BEEF || bif.m0_err !== 1'b0) begin
               bad++;
               $display("[TB] FAIL read_data got=%h err=%b exp=deadbeef err=0",
                        bif.m0_rdata, bif.m0_err);
            end
            total++;
            if (bif.bus_addr !== PARK) begin
               bad++;
               $display("[TB] FAIL read_park got=%h exp=%h", bif.bus_addr, PARK);
            end
            bif.m0_req = 1'b0;
            bif.bus_rdata = 32'h0;
         end
         if (k == 4) begin
            total++;
            if (bif.m0_rdata !== 32'hDEAD_BEEF) begin
               bad++;
               $display("[TB] FAIL read_hold got=%h exp=deadbeef", bif.m0_rdata);
            end
         end
      end
   endtask

   // Both masters request together right after reset and keep requesting:
   // grants alternate m0, m1, m0, m1, one transaction (4 cycles) each.
   task automatic test_arbitration();
      int   order[$];
      int   at[$];
      int   expOrd[4];
      int   expAt[4];
      logic p0;
      logic p1;
      expOrd = '{0, 1, 0, 1};
      expAt  = '{1, 5, 9, 13};
      p0 = 1'b0; p1 = 1'b0;
      doReset();
      bif.m0_req = 1'b1; bif.m0_addr = 32'h408; bif.m0_we = 1'b0;
      bif.m1_req = 1'b1; bif.m1_addr = 32'h40C; bif.m1_we = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         total++;
         if (bif.m0_gnt && bif.m1_gnt) begin
            bad++;
            $display("[TB] FAIL arb_gnt_onehot k=%0d got=11 exp=not both", k);
         end
         total++;
         if (bif.m0_ack && bif.m1_ack) begin
            bad++;
            $display("[TB] FAIL arb_ack_onehot k=%0d got=11 exp=not both", k);
         end
         if (bif.m0_gnt && !p0) begin order.push_back(0); at.push_back(k); end
         if (bif.m1_gnt && !p1) begin order.push_back(1); at.push_back(k); end
         p0 = bif.m0_gnt; p1 = bif.m1_gnt;
         if (order.size() == 4) break;
      end
      total++;
      if (order.size() != 4) begin
         bad++;
         $display("[TB] FAIL arb_grant_count got=%0d exp=4", order.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (order[i] != expOrd[i] || at[i] != expAt[i]) begin
               bad++;
               $display("[TB] FAIL arb_order i=%0d got=m%0d@%0d exp=m%0d@%0d",
                        i, order[i], at[i], expOrd[i], expAt[i]);
            end
         end
      end
      clearInputs();
   endtask

   // m1 writes 0x41 to the UART data register: one write-strobe cycle,
   // no read strobe, and m1's read data is not disturbed.
   task automatic test_uart_write();
      int ackCyc;
      doReset();
      bif.bus_rdata = 32'h1234_5678;
      runAccess(1'b1, 32'h500, 32'h41, 1'b1, ackCyc);
      total++;
      if (ackCyc != 3) begin
         bad++;
         $display("[TB] FAIL uart_ack_cycle got=%0d exp=3", ackCyc);
      end
      total++;
      if (weCycles != 1 || reCycles != 0) begin
         bad++;
         $display("[TB] FAIL uart_strobes got we=%0d re=%0d exp we=1 re=0", weCycles, reCycles);
      end
      total++;
      if (weAddr !== 32'h500 || weData !== 32'h41) begin
         bad++;
         $display("[TB] FAIL uart_bus got=%h/%h exp=00000500/00000041", weAddr, weData);
      end
      total++;
      if (bif.m1_err !== 1'b0 || bif.m0_ack !== 1'b0) begin
         bad++;
         $display("[TB] FAIL uart_err got err=%b m0_ack=%b exp 0/0", bif.m1_err, bif.m0_ack);
      end
      total++;
      if (bif.m1_rdata !== 32'h0) begin
         bad++;
         $display("[TB] FAIL uart_rdata_kept got=%h exp=0", bif.m1_rdata);
      end
   endtask

   // A legal ROM read loads non-zero read data, then each illegal access
   // (ROM writes incl. the top byte, unmapped, misaligned UART) must ack on
   // the next cycle with err=1, rdata cleared and the bus untouched.
   task automatic test_illegal();
      int          ackCyc;
      logic [31:0] badAddr[5];
      bit          badWe[5];
      badAddr = '{32'h010, 32'h600, 32'h502, 32'h505, 32'h3FF};
      badWe   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      doReset();
      bif.bus_rdata = 32'hCAFE_0001;
      runAccess(1'b0, 32'h3FC, 32'h0, 1'b0, ackCyc);
      total++;
      if (ackCyc != 3 || bif.m0_rdata !== 32'hCAFE_0001) begin
         bad++;
         $display("[TB] FAIL rom_read got=%0d/%h exp=3/cafe0001", ackCyc, bif.m0_rdata);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         runAccess(1'b0, badAddr[i], 32'hAA, badWe[i], ackCyc);
         total++;
         if (ackCyc != 1) begin
            bad++;
            $display("[TB] FAIL illegal_ack_cycle addr=%h got=%0d exp=1", badAddr[i], ackCyc);
         end
         total++;
         if (bif.m0_err !== 1'b1 || bif.m0_rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL illegal_resp addr=%h got err=%b rdata=%h exp err=1 rdata=0",
                     badAddr[i], bif.m0_err, bif.m0_rdata);
         end
         total++;
         if (sawValid || weCycles != 0 || reCycles != 0) begin
            bad++;
            $display("[TB] FAIL illegal_bus addr=%h got valid=%b we=%0d re=%0d exp 0/0/0",
                     badAddr[i], sawValid, weCycles, reCycles);
         end
      end
   endtask

   // Reset in the first ACCESS cycle of a UART read: everything drops at
   // once, no read strobe and no ack ever appear, and the bus is parked.
   task automatic test_reset_mid();
      bit sawRe;
      bit sawAck;
      sawRe = 1'b0; sawAck = 1'b0;
      doReset();
      bif.bus_rdata = 32'h77;
      bif.m0_req = 1'b1; bif.m0_addr = 32'h500; bif.m0_we = 1'b0;
      @(posedge clk);
      #2;
      total++;
      if (bif.bus_valid !== 1'b1 || bif.bus_re !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midrst_access got valid=%b re=%b exp 1/0", bif.bus_valid, bif.bus_re);
      end
      reset = 1'b1;
      #1;
      total++;
      if ({bif.m0_gnt, bif.bus_valid, bif.bus_re, bif.bus_we} !== 4'b0 || bif.bus_addr !== PARK) begin
         bad++;
         $display("[TB] FAIL midrst_async got=%b addr=%h exp=0000 addr=%h",
                  {bif.m0_gnt, bif.bus_valid, bif.bus_re, bif.bus_we}, bif.bus_addr, PARK);
      end
      bif.m0_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (bif.bus_re) sawRe = 1'b1;
         if (bif.m0_ack) sawAck = 1'b1;
      end
      total++;
      if (sawRe || sawAck) begin
         bad++;
         $display("[TB] FAIL midrst_quiet got re=%b ack=%b exp 0/0", sawRe, sawAck);
      end
      total++;
      if (bif.m0_gnt !== 1'b0 || bif.bus_addr !== PARK || bif.m0_rdata !== 32'h0) begin
         bad++;
         $display("[TB] FAIL midrst_idle got gnt=%b addr=%h rdata=%h exp 0/%h/0",
                  bif.m0_gnt, bif.bus_addr, bif.m0_rdata, PARK);
      end
   endtask

   // m0 keeps requesting across its ack while m1 asks during m0's ACCESS:
   // m1 goes next, then m0 again; each master's read data stays its own.
   task automatic test_back_to_back();
      int   order[$];
      int   at[$];
      int   expOrd[3];
      int   expAt[3];
      int   m0Acks;
      bit   done;
      logic p0;
      logic p1;
      expOrd = '{0, 1, 0};
      expAt  = '{1, 5, 9};
      m0Acks = 0; done = 1'b0; p0 = 1'b0; p1 = 1'b0;
      doReset();
      bif.bus_rdata = 32'h1111;
      bif.m0_req = 1'b1; bif.m0_addr = 32'h410; bif.m0_we = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            bif.m1_req = 1'b1; bif.m1_addr = 32'h414; bif.m1_we = 1'b0;
         end
         if (bif.m0_gnt && !p0) begin order.push_back(0); at.push_back(k); end
         if (bif.m1_gnt && !p1) begin order.push_back(1); at.push_back(k); end
         p0 = bif.m0_gnt; p1 = bif.m1_gnt;
         if (order.size() == 2) bif.bus_rdata = 32'h2222;
         if (order.size() == 3) bif.bus_rdata = 32'h3333;
         if (bif.m1_ack) begin
            total++;
            if (bif.m1_rdata !== 32'h2222 || bif.m0_rdata !== 32'h1111) begin
               bad++;
               $display("[TB] FAIL b2b_m1_data got m1=%h m0=%h exp 2222/1111",
                        bif.m1_rdata, bif.m0_rdata);
            end
            bif.m1_req = 1'b0;
         end
         if (bif.m0_ack) begin
            m0Acks++;
            if (m0Acks == 2) begin
               total++;
               if (bif.m0_rdata !== 32'h3333) begin
                  bad++;
                  $display("[TB] FAIL b2b_m0_data got=%h exp=3333", bif.m0_rdata);
               end
               bif.m0_req = 1'b0;
               done = 1'b1;
               break;
            end
         end
      end
      total++;
      if (!done || order.size() != 3) begin
         bad++;
         $display("[TB] FAIL b2b_complete got done=%b grants=%0d exp 1/3", done, order.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (order[i] != expOrd[i] || at[i] != expAt[i]) begin
               bad++;
               $display("[TB] FAIL b2b_order i=%0d got=m%0d@%0d exp=m%0d@%0d",
                        i, order[i], at[i], expOrd[i], expAt[i]);
            end
         end
      end
      clearInputs();
   endtask

   // Zero-wait instance: a single ACCESS cycle carries the strobe, ack comes
   // on the next cycle, and reset drops the strobe without waiting for a clock.
   task automatic test_zero_wait();
      doReset();
      bif0.bus_rdata = 32'h0BAD_F00D;
      bif0.m0_req = 1'b1; bif0.m0_addr = 32'h4FF; bif0.m0_we = 1'b0;
      @(negedge clk);
      total++;
      if ({bif0.bus_valid, bif0.bus_re, bif0.bus_we, bif0.m0_ack} !== 4'b1100 ||
          bif0.bus_addr !== 32'h4FF) begin
         bad++;
         $display("[TB] FAIL zw_read_access got=%b addr=%h exp=1100 addr=000004ff",
                  {bif0.bus_valid, bif0.bus_re, bif0.bus_we, bif0.m0_ack}, bif0.bus_addr);
      end
      @(negedge clk);
      total++;
      if (bif0.m0_ack !== 1'b1 || bif0.m0_rdata !== 32'h0BAD_F00D ||
          bif0.bus_valid !== 1'b0 || bif0.bus_re !== 1'b0) begin
         bad++;
         $display("[TB] FAIL zw_read_resp got ack=%b rdata=%h valid=%b re=%b exp 1/0badf00d/0/0",
                  bif0.m0_ack, bif0.m0_rdata, bif0.bus_valid, bif0.bus_re);
      end
      bif0.m0_req = 1'b0;
      @(negedge clk);
      bif0.m1_req = 1'b1; bif0.m1_addr = 32'h404; bif0.m1_wdata = 32'h99; bif0.m1_we = 1'b1;
      @(negedge clk);
      total++;
      if (bif0.bus_we !== 1'b1 || bif0.bus_re !== 1'b0 || bif0.bus_wdata !== 32'h99) begin
         bad++;
         $display("[TB] FAIL zw_write_access got we=%b re=%b wdata=%h exp 1/0/00000099",
                  bif0.bus_we, bif0.bus_re, bif0.bus_wdata);
      end
      @(negedge clk);
      total++;
      if (bif0.m1_ack !== 1'b1 || bif0.m1_err !== 1'b0 || bif0.bus_we !== 1'b0) begin
         bad++;
         $display("[TB] FAIL zw_write_resp got ack=%b err=%b we=%b exp 1/0/0",
                  bif0.m1_ack, bif0.m1_err, bif0.bus_we);
      end
      bif0.m1_req = 1'b0;
      @(negedge clk);
      bif0.m0_req = 1'b1; bif0.m0_addr = 32'h504; bif0.m0_we = 1'b0;
      @(negedge clk);
      total++;
      if (bif0.bus_re !== 1'b1) begin
         bad++;
         $display("[TB] FAIL zw_status_re got=%b exp=1", bif0.bus_re);
      end
      #1;
      reset = 1'b1;
      #1;
      total++;
      if (bif0.bus_re !== 1'b0 || bif0.bus_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL zw_async_drop got re=%b valid=%b exp 0/0", bif0.bus_re, bif0.bus_valid);
      end
      bif0.m0_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (bif0.m0_ack !== 1'b0 || bif0.m0_gnt !== 1'b0) begin
         bad++;
         $display("[TB] FAIL zw_no_ack got ack=%b gnt=%b exp 0/0", bif0.m0_ack, bif0.m0_gnt);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_read();
      test_arbitration();
      test_uart_write();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      test_zero_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared memory-mapped bus (ROM 0x000-0x3FF, RAM 0x400-0x4FF, UART data 0x500, UART status 0x504).
- Master 0 is the CPU data port. Master 1 is the UART boot/debug loader.
- Selects one requester round-robin, latches its request and drives the shared address/data/write lines into the address decoder for a fixed number of wait cycles.
- Returns read data with a one-cycle ack. Rejects unmapped accesses and ROM writes without touching the bus.

Parameters:
- WAIT_CYCLES, 1, extra ACCESS cycles beyond the first (range 0-15); the ACCESS phase lasts WAIT_CYCLES+1 cycles.
- PARK_ADDR, 32'h0, value driven on bus_addr when the bus is not in ACCESS.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req, m1_req  in  1  access request; held high until ack
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  write data
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_gnt, m1_gnt  out  1  master owns the bus (ACCESS and RESP states)
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_err, m1_err  out  1  valid with ack; 1 = rejected access
- m0_rdata, m1_rdata  out  32  read data; valid with ack, held until the next ack to that master
- bus_valid  out  1  high for every ACCESS cycle
- bus_addr  out  32  address to the decoder
- bus_wdata  out  32  write data to RAM/UART
- bus_we  out  1  MemWrite to the decoder
- bus_re  out  1  read strobe for side-effecting reads (UART RX pop)
- bus_rdata  in  32  read data from the ROM/RAM/UART mux

Behaviour:
- States: IDLE, ACCESS, RESP. All outputs are registered.
- Reset values:
  - State IDLE; last_grant=1, so master 0 wins the first tie.
  - All gnt/ack/err = 0; all rdata = 0.
  - bus_valid/bus_we/bus_re = 0; bus_addr = PARK_ADDR; bus_wdata = 0; wait counter = 0.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that master.
  - Both req: grant the master that is not last_grant, then update last_grant.
  - At grant, latch addr/wdata/we and check legality.
  - Illegal = address outside the four regions, address 0x500-0x503 other than 0x500, 0x504-0x507 other than 0x504, or any write to 0x000-0x3FF. Illegal goes directly to RESP with err=1 and rdata=0; the bus is not driven.
  - Legal goes to ACCESS with counter=WAIT_CYCLES.
- ACCESS:
  - bus_valid=1; bus_addr and bus_wdata = latched values.
  - Counter decrements each cycle.
  - In the final cycle (counter==0): bus_we=latched we, bus_re=~latched we, and bus_rdata is sampled into the granted master's rdata (reads only; rdata is unchanged on writes).
  - Next state RESP.
- RESP:
  - ack=1 and err valid for the granted master, for exactly one cycle; gnt still high.
  - bus_addr returns to PARK_ADDR; bus_valid/we/re = 0.
  - Next state IDLE.
- Latency, request sampled in IDLE at cycle T:
  - Legal access: ack at T+WAIT_CYCLES+2.
  - Illegal access: ack at T+1.
  - A new arbitration happens at T+WAIT_CYCLES+3 at the earliest.
- Requester rule: a req still high in the IDLE cycle after ack starts a new transaction. Changes to addr/wdata/we after grant are ignored.
- Fairness: with both requests held continuously, grants strictly alternate; neither master waits more than one transaction.
- A req of the non-granted master during ACCESS/RESP is held pending; it is not lost and not sampled early.
- Reset mid-transaction: immediate return to the reset values. No ack is issued for the aborted access, and bus_we/bus_re drop asynchronously.
- WAIT_CYCLES=0: ACCESS lasts one cycle, and we/re are asserted in that cycle.
- Counter width: 4 bits.

Test Plan:
1. m0 reads 0x404, WAIT_CYCLES=1, bus_rdata=0xDEADBEEF:
   - bus_valid high for 2 cycles; bus_re only in the 2nd.
   - m0_ack at T+3 with m0_rdata=0xDEADBEEF and m0_err=0.
2. m0 and m1 assert req in the same cycle after reset, both held:
   - Grant order m0, m1, m0, m1.
   - Exactly one gnt high at any time; never two acks in the same cycle.
3. m1 writes 0x41 to 0x500:
   - bus_we high for exactly 1 cycle with bus_addr=0x500 and bus_wdata=0x41.
   - m1_ack=1, m1_err=0.
4. m0 writes to 0x010, then reads 0x600:
   - Each access: ack at T+1 with err=1 and rdata=0.
   - bus_valid/bus_we never asserted.
5. Reset asserted in the 1st ACCESS cycle of an m0 read of 0x500:
   - bus_re never pulses and no m0_ack appears.
   - After release, state is IDLE and bus_addr=PARK_ADDR.
6. m0 holds req across its ack while m1 requests during m0's ACCESS:
   - m1 is granted next, then m0's second transaction.
